// File: rtl/tx_packet_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_packet_router: steers fixed-size inband packets to per-channel RAMs   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tx_packet_router #(
  parameter int NUM_CHAN  = 1,
  parameter int PKT_WORDS = 128,
  parameter int CMD_CHAN  = 31
) (
  input  logic                txclk,
  input  logic                reset,
  input  logic [31:0]         data_in,
  input  logic                data_valid,
  output logic [31:0]         ram_data,
  output logic [NUM_CHAN:0]   WR_channel,
  output logic [NUM_CHAN:0]   WR_done_channel,
  output logic [15:0]         drop_count,
  output logic                busy
);

  localparam int c_cw = $clog2(PKT_WORDS);
  localparam int c_tw = $clog2(NUM_CHAN + 1);
  localparam logic [c_cw-1:0]   c_last      = c_cw'(PKT_WORDS - 1);
  localparam logic [c_cw-1:0]   c_one       = c_cw'(1);
  localparam logic [5:0]        c_num_chan  = 6'(NUM_CHAN);
  localparam logic [4:0]        c_cmd_chan  = 5'(CMD_CHAN);
  localparam logic [c_tw-1:0]   c_cmd_index = c_tw'(NUM_CHAN);
  localparam logic [NUM_CHAN:0] c_oh_base   = (NUM_CHAN + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUTE = 2'd1,
    S_DROP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_cw-1:0] r_count;
  logic [c_tw-1:0] r_target;

  logic [4:0]      w_chan;
  logic            w_is_cmd;
  logic            w_is_data;
  logic            w_hdr_ok;
  logic [c_tw-1:0] w_hdr_target;
  logic            w_last;

  assign w_chan    = data_in[20:16];
  assign w_is_cmd  = (w_chan == c_cmd_chan);
  assign w_is_data = ({1'b0, w_chan} < c_num_chan);
  assign w_hdr_ok  = w_is_cmd | w_is_data;
  assign w_last    = (r_count == c_last);

  always_comb begin
    w_hdr_target = c_tw'(w_chan);
    if (w_is_cmd)
      w_hdr_target = c_cmd_index;
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge txclk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_count         <= '0;
      r_target        <= '0;
      ram_data        <= '0;
      WR_channel      <= '0;
      WR_done_channel <= '0;
      drop_count      <= '0;
    end else begin
      WR_channel      <= '0;
      WR_done_channel <= '0;
      ram_data        <= data_in;
      case (r_state)
        // DONE doubles as IDLE so a header arriving right after a packet is not lost
        S_IDLE, S_DONE: begin
          if (r_state == S_DONE)
            WR_done_channel <= c_oh_base << r_target;
          if (data_valid) begin
            r_count <= c_one;
            if (w_hdr_ok) begin
              r_state    <= S_ROUTE;
              r_target   <= w_hdr_target;
              WR_channel <= c_oh_base << w_hdr_target;
            end else begin
              r_state <= S_DROP;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ROUTE: begin
          if (data_valid) begin
            WR_channel <= c_oh_base << r_target;
            r_count    <= r_count + c_one;
            if (w_last)
              r_state <= S_DONE;
          end
        end
        S_DROP: begin
          if (data_valid) begin
            r_count <= r_count + c_one;
            if (w_last) begin
              r_state <= S_IDLE;
              if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_packet_router.sv
`default_nettype none
// Scoreboard bench for tx_packet_router: expected writes queued at drive time, checked at output.
module tb_tx_packet_router;
  localparam int NUM_CHAN  = 1;
  localparam int PKT_WORDS = 128;

  logic        txclk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic [31:0] ram_data;
  logic [1:0]  WR_channel;
  logic [1:0]  WR_done_channel;
  logic [15:0] drop_count;
  logic        busy;

  always #5 txclk = ~txclk;

  tx_packet_router #(.NUM_CHAN(NUM_CHAN), .PKT_WORDS(PKT_WORDS), .CMD_CHAN(31)) dut (
    .txclk(txclk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .ram_data(ram_data), .WR_channel(WR_channel), .WR_done_channel(WR_done_channel),
    .drop_count(drop_count), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  oh;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   pend_done = 0;
  logic [1:0] pend_done_oh = '0;
  int   wr_cnt0 = 0;
  int   wr_cnt1 = 0;
  int   done_cnt = 0;

  always @(negedge txclk) begin
    if (mon_en) begin
      if (pend_done) begin
        checks++;
        if (WR_done_channel !== pend_done_oh) begin
          errors++;
          $display("FAIL wr_done: got %b want %b", WR_done_channel, pend_done_oh);
        end
        pend_done = 0;
      end else if (WR_done_channel !== 2'b00) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got %b want 00", WR_done_channel);
      end
      if (WR_done_channel !== 2'b00) done_cnt++;
      if (WR_channel !== 2'b00) begin
        if (WR_channel[0] === 1'b1) wr_cnt0++;
        if (WR_channel[1] === 1'b1) wr_cnt1++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr: got ch %b data %h want no write", WR_channel, ram_data);
        end else begin
          m_e = sb.pop_front();
          if (WR_channel !== m_e.oh || ram_data !== m_e.data) begin
            errors++;
            $display("FAIL wr_word: got ch %b data %h want ch %b data %h",
                     WR_channel, ram_data, m_e.oh, m_e.data);
          end
          if (m_e.last) begin
            pend_done    = 1;
            pend_done_oh = m_e.oh;
          end
        end
      end
    end
  end

  task automatic clear_counts();
    wr_cnt0  = 0;
    wr_cnt1  = 0;
    done_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge txclk);
      data_valid = 1'b0;
      data_in    = $urandom;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [1:0] oh, input bit last);
    @(negedge txclk);
    data_in    = w;
    data_valid = 1'b1;
    if (oh != 2'b00) sb.push_back('{data: w, oh: oh, last: last});
  endtask

  task automatic send_packet(input int chan, input bit gappy, input int n_words);
    logic [1:0]  oh;
    logic [31:0] w;
    logic [4:0]  c5;
    c5 = chan[4:0];
    if (chan == 31)            oh = 2'b10;
    else if (chan < NUM_CHAN)  oh = 2'b01 << chan;
    else                       oh = 2'b00;
    for (int i = 0; i < n_words; i++) begin
      w = $urandom;
      if (i == 0) w[20:16] = c5;
      send_word(w, oh, i == PKT_WORDS - 1);
      if (gappy) begin
        if (i == 63) begin
          idle(10);
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_gap: got %b want 1", busy);
          end
        end else if (i % 2 == 1) begin
          idle(1);
        end
      end
    end
  endtask

  task automatic check_counts(input string name, input int e0, input int e1, input int ed);
    checks++;
    if (wr_cnt0 !== e0 || wr_cnt1 !== e1 || done_cnt !== ed || sb.size() !== 0) begin
      errors++;
      $display("FAIL %s: got wr0 %0d wr1 %0d done %0d left %0d want wr0 %0d wr1 %0d done %0d left 0",
               name, wr_cnt0, wr_cnt1, done_cnt, sb.size(), e0, e1, ed);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (WR_channel !== 2'b00 || WR_done_channel !== 2'b00 || ram_data !== 32'h0 ||
        drop_count !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got wr %b done %b data %h drops %h busy %b want all 0",
               name, WR_channel, WR_done_channel, ram_data, drop_count, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_valid = 1'b0;
    repeat (3) @(negedge txclk);
    check_quiet("reset_state");
    reset = 1'b0;
    mon_en = 1;
  endtask

  task automatic test_chan0();
    clear_counts();
    send_packet(0, 0, PKT_WORDS);
    idle(4);
    check_counts("chan0_packet", PKT_WORDS, 0, 1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_packet: got %b want 0", busy);
    end
  endtask

  task automatic test_cmd_chan();
    clear_counts();
    send_packet(31, 0, PKT_WORDS);
    idle(4);
    check_counts("cmd_packet", 0, PKT_WORDS, 1);
  endtask

  task automatic test_drop();
    checks++;
    if (drop_count !== 16'd0) begin
      errors++;
      $display("FAIL drop_before: got %0d want 0", drop_count);
    end
    clear_counts();
    send_packet(5, 0, PKT_WORDS);
    idle(3);
    check_counts("dropped_packet", 0, 0, 0);
    checks++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_after: got %0d want 1", drop_count);
    end
    clear_counts();
    send_packet(0, 0, PKT_WORDS);
    idle(4);
    check_counts("after_drop_packet", PKT_WORDS, 0, 1);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_packet(0, 0, PKT_WORDS);
    send_packet(31, 0, PKT_WORDS);
    send_packet(0, 0, PKT_WORDS);
    idle(4);
    check_counts("back_to_back", 2 * PKT_WORDS, PKT_WORDS, 3);
  endtask

  task automatic test_gaps();
    clear_counts();
    send_packet(0, 1, PKT_WORDS);
    idle(4);
    check_counts("gappy_packet", PKT_WORDS, 0, 1);
  endtask

  task automatic test_reset_mid();
    clear_counts();
    send_packet(0, 0, 50);
    @(negedge txclk);
    reset      = 1'b1;
    data_valid = 1'b0;
    @(negedge txclk);
    check_quiet("reset_mid_outputs");
    reset = 1'b0;
    idle(2);
    send_packet(0, 0, PKT_WORDS);
    idle(4);
    check_counts("after_reset_packet", 50 + PKT_WORDS, 0, 1);
  endtask

  initial begin
    test_reset();
    test_chan0();
    test_cmd_chan();
    test_drop();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
